// File: rtl/iob_dma_axis_packer.sv
// iob_dma_axis_packer
// Packs a narrow byte stream into OUT_W-bit AXIS words for the DMA input.
// A partial word is flushed, zero padded, on in_tlast_i or after timeout_i
// idle cycles. One packing accumulator plus one output register let input
// keep flowing while the DMA stalls a single word; a second emit while the
// output is still busy parks the accumulator (HOLD) and blocks input.

module iob_dma_axis_packer #(
   parameter int IN_W      = 8,
   parameter int OUT_W     = 32,
   parameter int TIMEOUT_W = 16
) (
   input  logic                 clk_i,
   input  logic                 arst_n_i,
   input  logic                 cke_i,
   input  logic                 rst_i,
   input  logic [TIMEOUT_W-1:0] timeout_i,
   input  logic [IN_W-1:0]      in_tdata_i,
   input  logic                 in_tvalid_i,
   input  logic                 in_tlast_i,
   output logic                 in_tready_o,
   output logic [OUT_W-1:0]     out_tdata_o,
   output logic [OUT_W/IN_W-1:0] out_tkeep_o,
   output logic                 out_tvalid_o,
   input  logic                 out_tready_i,
   output logic [31:0]          word_cnt_o
);

   localparam int R     = OUT_W / IN_W;
   // lane_cnt must be able to hold R (a full word parked in HOLD)
   localparam int CNT_W = $clog2(R + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,  // accumulator empty
      FILL = 2'd1,  // 0 < lane_cnt < R
      HOLD = 2'd2   // word ready, output register busy, input blocked
   } state_t;

   state_t               state_q, state_d;
   logic [OUT_W-1:0]     acc_q, acc_d;
   logic [CNT_W-1:0]     lane_cnt_q, lane_cnt_d;
   logic [TIMEOUT_W-1:0] idle_cnt_q, idle_cnt_d;

   logic [OUT_W-1:0]     out_data_d;
   logic [R-1:0]         out_keep_d;
   logic                 out_valid_d;
   logic [31:0]          word_cnt_d;

   logic                 beat;
   logic                 out_free;
   logic                 out_hs;
   logic                 timeout_hit;
   logic                 emit;
   logic                 load;
   logic [OUT_W-1:0]     acc_merged;
   logic [CNT_W-1:0]     cnt_merged;
   logic [OUT_W-1:0]     pack_data;
   logic [R-1:0]         pack_keep;

   // Ready depends on state only, so there is no path from out_tready_i
   assign in_tready_o = (state_q != HOLD);
   assign beat        = in_tvalid_i & in_tready_o & cke_i;
   assign out_free    = ~out_tvalid_o | out_tready_i;
   assign out_hs      = out_tvalid_o & out_tready_i;

   // Merge the incoming lane into the accumulator and build the padded word
   always_comb begin
      // NOTE: every variable gets a default before any branch, otherwise a path that skips the assignment infers a latch.
      acc_merged = acc_q;
      pack_data  = '0;
      pack_keep  = '0;
      for (int i = 0; i < R; i++) begin
         if (beat && (lane_cnt_q == CNT_W'(i))) begin
            acc_merged[i*IN_W +: IN_W] = in_tdata_i;
         end
      end
      cnt_merged = lane_cnt_q + {{(CNT_W-1){1'b0}}, beat};
      for (int i = 0; i < R; i++) begin
         pack_keep[i] = (CNT_W'(i) < cnt_merged);
         if (pack_keep[i]) begin
            pack_data[i*IN_W +: IN_W] = acc_merged[i*IN_W +: IN_W];
         end
      end
   end

   // Emit events: word filled, tlast, or idle timeout while partially filled
   always_comb begin
      timeout_hit = ~beat && (state_q == FILL) && (timeout_i != '0)
                    && (idle_cnt_q == timeout_i);
      emit        = (beat && ((cnt_merged == CNT_W'(R)) || in_tlast_i)) || timeout_hit;
   end

   // Next-state and datapath decisions for the packer FSM
   always_comb begin
      state_d     = state_q;
      acc_d       = acc_q;
      lane_cnt_d  = lane_cnt_q;
      idle_cnt_d  = idle_cnt_q;
      load        = 1'b0;
      out_valid_d = out_tvalid_o & ~out_hs;
      out_data_d  = out_tdata_o;
      out_keep_d  = out_tkeep_o;
      word_cnt_d  = word_cnt_o + 32'(out_hs);

      case (state_q)
         IDLE, FILL: begin
            acc_d      = acc_merged;
            lane_cnt_d = cnt_merged;
            if (beat || state_q == IDLE) begin
               idle_cnt_d = '0;
            end else if (idle_cnt_q != '1) begin
               idle_cnt_d = idle_cnt_q + 1'b1;
            end
            if (emit) begin
               idle_cnt_d = '0;
               if (out_free) begin
                  load       = 1'b1;
                  acc_d      = '0;
                  lane_cnt_d = '0;
                  state_d    = IDLE;
               end else begin
                  state_d = HOLD;
               end
            end else if (beat) begin
               state_d = FILL;
            end
         end
         HOLD: begin
            idle_cnt_d = '0;
            if (out_free) begin
               load       = 1'b1;
               acc_d      = '0;
               lane_cnt_d = '0;
               state_d    = IDLE;
            end
         end
         default: begin
            state_d    = IDLE;
            acc_d      = '0;
            lane_cnt_d = '0;
            idle_cnt_d = '0;
         end
      endcase

      // In HOLD there is no beat, so the merged view equals the frozen accumulator
      if (load) begin
         out_valid_d = 1'b1;
         out_data_d  = pack_data;
         out_keep_d  = pack_keep;
      end
   end

   // State and output registers, frozen while cke_i is low
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      // NOTE: the accumulator is a plain register, not a memory, so it is reset together with everything else.
      if (!arst_n_i) begin
         state_q      <= IDLE;
         acc_q        <= '0;
         lane_cnt_q   <= '0;
         idle_cnt_q   <= '0;
         out_tvalid_o <= 1'b0;
         out_tdata_o  <= '0;
         out_tkeep_o  <= '0;
         word_cnt_o   <= '0;
      end else if (cke_i) begin
         if (rst_i) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            lane_cnt_q   <= '0;
            idle_cnt_q   <= '0;
            out_tvalid_o <= 1'b0;
            out_tdata_o  <= '0;
            out_tkeep_o  <= '0;
            word_cnt_o   <= '0;
         end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q      <= state_d;
            acc_q        <= acc_d;
            lane_cnt_q   <= lane_cnt_d;
            idle_cnt_q   <= idle_cnt_d;
            out_tvalid_o <= out_valid_d;
            out_tdata_o  <= out_data_d;
            out_tkeep_o  <= out_keep_d;
            word_cnt_o   <= word_cnt_d;
         end
      end
   end

endmodule

// File: tb/tb_iob_dma_axis_packer.sv
// tb_iob_dma_axis_packer
// Directed scenarios followed by a randomized phase. A byte-queue reference
// model predicts every output after each clock edge.

module tb_iob_dma_axis_packer;

   localparam int IN_W      = 8;
   localparam int OUT_W     = 32;
   localparam int TIMEOUT_W = 16;
   localparam int R         = OUT_W / IN_W;

   logic                 clk_i = 1'b0;
   logic                 arst_n_i;
   logic                 cke_i;
   logic                 rst_i;
   logic [TIMEOUT_W-1:0] timeout_i;
   logic [IN_W-1:0]      in_tdata_i;
   logic                 in_tvalid_i;
   logic                 in_tlast_i;
   logic                 in_tready_o;
   logic [OUT_W-1:0]     out_tdata_o;
   logic [R-1:0]         out_tkeep_o;
   logic                 out_tvalid_o;
   logic                 out_tready_i;
   logic [31:0]          word_cnt_o;

   iob_dma_axis_packer #(
      .IN_W      (IN_W),
      .OUT_W     (OUT_W),
      .TIMEOUT_W (TIMEOUT_W)
   ) dut (
      .clk_i        (clk_i),
      .arst_n_i     (arst_n_i),
      .cke_i        (cke_i),
      .rst_i        (rst_i),
      .timeout_i    (timeout_i),
      .in_tdata_i   (in_tdata_i),
      .in_tvalid_i  (in_tvalid_i),
      .in_tlast_i   (in_tlast_i),
      .in_tready_o  (in_tready_o),
      .out_tdata_o  (out_tdata_o),
      .out_tkeep_o  (out_tkeep_o),
      .out_tvalid_o (out_tvalid_o),
      .out_tready_i (out_tready_i),
      .word_cnt_o   (word_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: pending bytes as a queue, one parked word, one output word
   logic [7:0]  m_acc[$];
   int unsigned m_idle;
   bit          m_hold;
   logic [31:0] m_hold_data;
   logic [3:0]  m_hold_keep;
   logic        m_valid;
   logic [31:0] m_data;
   logic [3:0]  m_keep;
   logic [31:0] m_cnt;

   task automatic model_reset();
      m_acc.delete();
      m_idle      = 0;
      m_hold      = 0;
      m_hold_data = '0;
      m_hold_keep = '0;
      m_valid     = 1'b0;
      m_data      = '0;
      m_keep      = '0;
      m_cnt       = '0;
   endtask

   task automatic model_step();
      bit          beat;
      bit          free;
      bit          emit;
      logic [31:0] w;
      logic [3:0]  k;
      if (!cke_i) return;
      if (rst_i) begin
         model_reset();
         return;
      end
      beat = in_tvalid_i && !m_hold;
      free = !m_valid || out_tready_i;
      if (m_valid && out_tready_i) begin
         m_cnt++;
         m_valid = 1'b0;
      end
      if (m_hold) begin
         if (free) begin
            m_data  = m_hold_data;
            m_keep  = m_hold_keep;
            m_valid = 1'b1;
            m_hold  = 0;
         end
         return;
      end
      emit = 0;
      if (beat) begin
         m_acc.push_back(in_tdata_i);
         m_idle = 0;
         emit   = (m_acc.size() == R) || in_tlast_i;
      end else if (m_acc.size() != 0) begin
         if (timeout_i != 0 && m_idle == timeout_i) emit = 1;
         else if (m_idle < 65535) m_idle++;
      end
      if (emit) begin
         w = '0;
         foreach (m_acc[i]) w |= 32'(m_acc[i]) << (8 * i);
         k = 4'((1 << m_acc.size()) - 1);
         m_acc.delete();
         m_idle = 0;
         if (free) begin
            m_data  = w;
            m_keep  = k;
            m_valid = 1'b1;
         end else begin
            m_hold      = 1;
            m_hold_data = w;
            m_hold_keep = k;
         end
      end
   endtask

   task automatic compare_all(input string tag);
      check({tag, ".tready"}, 32'(in_tready_o), 32'(!m_hold));
      check({tag, ".tvalid"}, 32'(out_tvalid_o), 32'(m_valid));
      check({tag, ".tdata"}, out_tdata_o, m_data);
      check({tag, ".tkeep"}, 32'(out_tkeep_o), 32'(m_keep));
      check({tag, ".wcnt"}, word_cnt_o, m_cnt);
   endtask

   // One clock: DUT and model both see the inputs set before the edge
   task automatic cycle(input string tag);
      @(posedge clk_i);
      model_step();
      #1;
      compare_all(tag);
   endtask

   task automatic drive(input logic v, input logic [7:0] d, input logic last, input string tag);
      in_tvalid_i = v;
      in_tdata_i  = d;
      in_tlast_i  = last;
      cycle(tag);
   endtask

   int   found;
   logic [31:0] found_data;
   logic [3:0]  found_keep;
   bit   seen;

   initial begin
      arst_n_i     = 1'b1;
      cke_i        = 1'b1;
      rst_i        = 1'b0;
      timeout_i    = '0;
      in_tdata_i   = '0;
      in_tvalid_i  = 1'b0;
      in_tlast_i   = 1'b0;
      out_tready_i = 1'b1;
      model_reset();
      #2 arst_n_i = 1'b0;
      #6;
      compare_all("reset");
      @(negedge clk_i);
      arst_n_i = 1'b1;

      // Full word, one byte per cycle
      drive(1'b1, 8'h11, 1'b0, "fw0");
      drive(1'b1, 8'h22, 1'b0, "fw1");
      drive(1'b1, 8'h33, 1'b0, "fw2");
      drive(1'b1, 8'h44, 1'b0, "fw3");
      check("fw.data", out_tdata_o, 32'h44332211);
      check("fw.keep", 32'(out_tkeep_o), 32'hF);
      check("fw.valid", 32'(out_tvalid_o), 32'd1);
      drive(1'b0, 8'h00, 1'b0, "fw.idle");
      check("fw.wcnt", word_cnt_o, 32'd1);

      // Backpressure: two words, the second parks in HOLD
      out_tready_i = 1'b0;
      for (int i = 1; i <= 8; i++) drive(1'b1, 8'(i), 1'b0, "bp.in");
      check("bp.hold_ready", 32'(in_tready_o), 32'd0);
      check("bp.first", out_tdata_o, 32'h04030201);
      drive(1'b0, 8'h00, 1'b0, "bp.stall");
      check("bp.stable", out_tdata_o, 32'h04030201);
      out_tready_i = 1'b1;
      drive(1'b0, 8'h00, 1'b0, "bp.rel0");
      check("bp.second", out_tdata_o, 32'h08070605);
      check("bp.second_valid", 32'(out_tvalid_o), 32'd1);
      check("bp.wcnt1", word_cnt_o, 32'd2);
      drive(1'b0, 8'h00, 1'b0, "bp.rel1");
      check("bp.wcnt2", word_cnt_o, 32'd3);

      // tlast flush of a partial word, next byte starts at lane 0
      drive(1'b1, 8'hAA, 1'b0, "tl0");
      drive(1'b1, 8'hBB, 1'b1, "tl1");
      check("tl.data", out_tdata_o, 32'h0000BBAA);
      check("tl.keep", 32'(out_tkeep_o), 32'h3);
      drive(1'b1, 8'hCC, 1'b1, "tl2");
      check("tl.lane0", out_tdata_o, 32'h000000CC);
      check("tl.keep1", 32'(out_tkeep_o), 32'h1);
      drive(1'b0, 8'h00, 1'b0, "tl.idle");

      // Timeout flush: the beat's own edge plus 6 idle edges = 7 edges
      timeout_i = 16'd5;
      drive(1'b1, 8'h01, 1'b0, "to0");
      drive(1'b1, 8'h02, 1'b0, "to1");
      drive(1'b1, 8'h03, 1'b0, "to2");
      found = -1;
      found_data = '0;
      found_keep = '0;
      for (int k = 1; k <= 20; k++) begin
         drive(1'b0, 8'h00, 1'b0, "to.idle");
         if (out_tvalid_o && found < 0) begin
            found      = k;
            found_data = out_tdata_o;
            found_keep = out_tkeep_o;
         end
      end
      check("to.idle_edges", 32'(found), 32'd6);
      check("to.data", found_data, 32'h00030201);
      check("to.keep", 32'(found_keep), 32'h7);

      // Timeout disabled: the same stimulus never emits
      timeout_i = 16'd0;
      drive(1'b1, 8'h01, 1'b0, "nt0");
      drive(1'b1, 8'h02, 1'b0, "nt1");
      drive(1'b1, 8'h03, 1'b0, "nt2");
      seen = 0;
      for (int k = 1; k <= 20; k++) begin
         drive(1'b0, 8'h00, 1'b0, "nt.idle");
         if (out_tvalid_o) seen = 1;
      end
      check("nt.no_emit", 32'(seen), 32'd0);
      drive(1'b1, 8'h04, 1'b1, "nt.flush");
      check("nt.data", out_tdata_o, 32'h04030201);
      drive(1'b0, 8'h00, 1'b0, "nt.idle2");

      // Clock enable low freezes everything, beats are not taken
      drive(1'b1, 8'h10, 1'b0, "ck0");
      drive(1'b1, 8'h20, 1'b0, "ck1");
      cke_i = 1'b0;
      for (int k = 0; k < 3; k++) drive(1'b1, 8'h55, 1'b1, "ck.frozen");
      cke_i = 1'b1;
      drive(1'b1, 8'h30, 1'b1, "ck2");
      check("ck.data", out_tdata_o, 32'h00302010);
      check("ck.keep", 32'(out_tkeep_o), 32'h7);
      drive(1'b0, 8'h00, 1'b0, "ck.idle");

      // Async reset mid-word discards the partial word
      drive(1'b1, 8'hA1, 1'b0, "ar0");
      drive(1'b1, 8'hA2, 1'b0, "ar1");
      in_tvalid_i = 1'b0;
      in_tlast_i  = 1'b0;
      arst_n_i    = 1'b0;
      model_reset();
      #1;
      compare_all("arst");
      check("arst.ready", 32'(in_tready_o), 32'd1);
      check("arst.wcnt", word_cnt_o, 32'd0);
      @(posedge clk_i);
      #4 arst_n_i = 1'b1;
      drive(1'b1, 8'hB1, 1'b0, "ar2");
      drive(1'b1, 8'hB2, 1'b0, "ar3");
      drive(1'b1, 8'hB3, 1'b0, "ar4");
      drive(1'b1, 8'hB4, 1'b0, "ar5");
      check("ar.data", out_tdata_o, 32'hB4B3B2B1);
      check("ar.keep", 32'(out_tkeep_o), 32'hF);
      drive(1'b0, 8'h00, 1'b0, "ar.idle");

      // Sync clear while a word is stalled on the output
      out_tready_i = 1'b0;
      drive(1'b1, 8'hC1, 1'b0, "sr0");
      drive(1'b1, 8'hC2, 1'b0, "sr1");
      drive(1'b1, 8'hC3, 1'b0, "sr2");
      drive(1'b1, 8'hC4, 1'b0, "sr3");
      drive(1'b0, 8'h00, 1'b0, "sr.stall");
      check("sr.stalled", 32'(out_tvalid_o), 32'd1);
      rst_i = 1'b1;
      drive(1'b0, 8'h00, 1'b0, "sr.clear");
      rst_i = 1'b0;
      check("sr.valid", 32'(out_tvalid_o), 32'd0);
      check("sr.wcnt", word_cnt_o, 32'd0);
      check("sr.data", out_tdata_o, 32'd0);
      out_tready_i = 1'b1;

      // Randomized traffic against the model
      for (int n = 0; n < 600; n++) begin
         if (n % 60 == 0) begin
            case ($urandom_range(0, 2))
               0:       timeout_i = 16'd0;
               1:       timeout_i = 16'd2;
               default: timeout_i = 16'd5;
            endcase
         end
         cke_i        = ($urandom_range(0, 9) != 0);
         rst_i        = ($urandom_range(0, 149) == 0);
         out_tready_i = ($urandom_range(0, 3) != 0);
         drive(1'($urandom_range(0, 1)), 8'($urandom), ($urandom_range(0, 7) == 0), "rnd");
      end
      cke_i        = 1'b1;
      rst_i        = 1'b0;
      out_tready_i = 1'b1;
      in_tvalid_i  = 1'b0;
      for (int k = 0; k < 4; k++) cycle("drain");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
